load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 53 +++++
 rtl/load_store_unit_if.sv | 20 ++
 rtl/lsu_load_align.sv | 25 ++
 rtl/load_store_unit.sv | 121 ++++++++++++
 tb/tb_load_store_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and request helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic lsu_legal(input logic store, input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~store;
            F3_HU:   ok = ~store & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lsu_byte_en(input logic store, input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        if (store) begin
            case (f3)
                F3_B:    be = 4'b0001 << off;
                F3_H:    be = 4'b0011 << {off[1], 1'b0};
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    // Narrow stores replicate the datum across every lane; byte enables pick the live one.
    function automatic logic [31:0] lsu_store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3)
            F3_B:    w = {4{d[7:0]}};
            F3_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - memory-side request/ack bus of the load/store unit
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - lane selection and sign/zero extension of load data
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = 8'(word >> {offset, 3'b000});
        lane_h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_BU:   result = {24'd0, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_HU:   result = {16'd0, lane_h};
            F3_W:    result = word;
            default: result = 32'd0;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with ack timeout
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      core_valid,
    input  logic                      core_store,
    input  logic [2:0]                core_funct3,
    input  logic [31:0]               core_addr,
    input  logic [31:0]               core_wdata,
    output logic [31:0]               core_rdata,
    output logic                      core_done,
    output logic                      core_err,
    output logic                      core_stall,
    load_store_unit_if.master         mem
);
    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_e    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [3:0]    be_q, be_d;
    logic [2:0]    f3_q, f3_d;
    logic          store_q, store_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   load_word;

    lsu_load_align u_align (
        .word   (mem.mem_rdata),
        .offset (addr_q[1:0]),
        .funct3 (f3_q),
        .result (load_word)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            store_q <= store_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        store_d = store_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (core_valid) begin
                    if (lsu_legal(core_store, core_funct3, core_addr[1:0])) begin
                        state_d = ACCESS;
                        addr_d  = core_addr;
                        f3_d    = core_funct3;
                        store_d = core_store;
                        be_d    = lsu_byte_en(core_store, core_funct3, core_addr[1:0]);
                        wdata_d = core_store ? lsu_store_data(core_funct3, core_wdata) : 32'd0;
                        cnt_d   = '0;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end
                end
            end
            ACCESS: begin
                // An ack landing in the final timeout cycle still completes cleanly.
                if (mem.mem_ack) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    rdata_d = store_q ? 32'd0 : load_word;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem.mem_req   = (state_q == ACCESS);
    assign mem.mem_we    = (state_q == ACCESS) && store_q;
    assign mem.mem_addr  = {addr_q[31:2], 2'b00};
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

    assign core_rdata = rdata_q;
    assign core_done  = (state_q == DONE);
    assign core_err   = core_done && err_q;
    assign core_stall = core_valid && !core_done;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector table plus randomized model-checked transactions
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_valid, core_store;
    logic [2:0]  core_funct3;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_done, core_err, core_stall;

    always #5 clk = ~clk;

    load_store_unit_if mem ();

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .core_valid  (core_valid),
        .core_store  (core_store),
        .core_funct3 (core_funct3),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_rdata  (core_rdata),
        .core_done   (core_done),
        .core_err    (core_err),
        .core_stall  (core_stall),
        .mem         (mem)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        int          dly;
        logic [31:0] mr;
        logic        legal;
        logic        err;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] mwd;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: size in bytes is 1 << funct3[1:0], alignment by modulo.
    function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        if (st && f3 > 3'd2) return 1'b0;
        if (!st && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        sz = 1 << f3[1:0];
        return (a % sz) == 0;
    endfunction

    function automatic logic [3:0] m_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        if (!st) return 4'hF;
        sz = 1 << f3[1:0];
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz;
        sz = 1 << f3[1:0];
        if (sz == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int sz;
        logic [31:0] v, mask;
        sz = 1 << f3[1:0];
        v = w >> (8 * (a % 4));
        if (sz == 4) return v;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = v & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic do_txn(input string tag, input vec_t v);
        int reqs, cyc, exp_reqs;
        logic [31:0] held_rd;
        bit done;
        reqs = 0;
        cyc = 0;
        done = 0;
        exp_reqs = !v.legal ? 0 : (v.dly < TIMEOUT ? v.dly + 1 : TIMEOUT);
        core_valid  = 1'b1;
        core_store  = v.st;
        core_funct3 = v.f3;
        core_addr   = v.a;
        core_wdata  = v.wd;
        while (!done && cyc < TIMEOUT + 8) begin
            tick;
            cyc++;
            if (mem.mem_req) begin
                reqs++;
                chk({tag, " mem_addr"}, mem.mem_addr, v.a & 32'hFFFF_FFFC);
                chk({tag, " mem_be"}, {28'd0, mem.mem_be}, {28'd0, v.be});
                chk({tag, " mem_we"}, {31'd0, mem.mem_we}, {31'd0, v.st});
                if (v.st) chk({tag, " mem_wdata"}, mem.mem_wdata, v.mwd);
                chk({tag, " stall"}, {31'd0, core_stall}, 32'd1);
                mem.mem_ack   = (reqs == v.dly + 1);
                mem.mem_rdata = mem.mem_ack ? v.mr : $urandom;
            end else begin
                mem.mem_ack = 1'b0;
            end
            if (core_done) begin
                done = 1;
                chk({tag, " err"}, {31'd0, core_err}, {31'd0, v.err});
                chk({tag, " rdata"}, core_rdata, v.rd);
                chk({tag, " stall_at_done"}, {31'd0, core_stall}, 32'd0);
                chk({tag, " req_cycles"}, reqs, exp_reqs);
                chk({tag, " done_latency"}, cyc, reqs + 1);
            end
        end
        if (!done) chk({tag, " done_within_bound"}, 32'd0, 32'd1);
        held_rd = core_rdata;
        core_valid = 1'b0;
        mem.mem_ack = 1'b0;
        tick;
        chk({tag, " done_one_cycle"}, {31'd0, core_done}, 32'd0);
        chk({tag, " rdata_hold"}, core_rdata, held_rd);
    endtask

    initial begin
        vec_t rv;
        reset = 1'b0;
        core_valid = 1'b0;
        core_store = 1'b0;
        core_funct3 = 3'd0;
        core_addr = 32'd0;
        core_wdata = 32'd0;
        mem.mem_ack = 1'b0;
        mem.mem_rdata = 32'd0;

        //       st  f3     addr          wdata         dly       mem_rdata     legal err rdata         be       mem_wdata
        vt[0]  = '{0, F3_W,  32'h0000_0100, 32'h0,        2,        32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 4'hF,    32'h0};
        vt[1]  = '{0, F3_B,  32'h0000_0103, 32'h0,        0,        32'h80FF_0000, 1, 0, 32'hFFFF_FF80, 4'hF,    32'h0};
        vt[2]  = '{0, F3_BU, 32'h0000_0103, 32'h0,        1,        32'h80FF_0000, 1, 0, 32'h0000_0080, 4'hF,    32'h0};
        vt[3]  = '{1, F3_H,  32'h0000_0022, 32'h1234_ABCD, 0,        32'h5555_5555, 1, 0, 32'h0,        4'b1100, 32'hABCD_ABCD};
        vt[4]  = '{0, F3_W,  32'h0000_0101, 32'h0,        0,        32'h0,        0, 1, 32'h0,        4'h0,    32'h0};
        vt[5]  = '{0, F3_W,  32'h0000_0200, 32'h0,        99,       32'h0,        1, 1, 32'h0,        4'hF,    32'h0};
        vt[6]  = '{0, F3_W,  32'h0000_0204, 32'h0,        TIMEOUT-1, 32'h1122_3344, 1, 0, 32'h1122_3344, 4'hF,    32'h0};
        vt[7]  = '{0, F3_H,  32'h0000_0102, 32'h0,        0,        32'h8001_7FFF, 1, 0, 32'hFFFF_8001, 4'hF,    32'h0};
        vt[8]  = '{0, F3_HU, 32'h0000_0102, 32'h0,        3,        32'h8001_7FFF, 1, 0, 32'h0000_8001, 4'hF,    32'h0};
        vt[9]  = '{1, F3_B,  32'h0000_0041, 32'h0000_00A5, 0,        32'h0,        1, 0, 32'h0,        4'b0010, 32'hA5A5_A5A5};
        vt[10] = '{0, 3'b011, 32'h0000_0000, 32'h0,       0,        32'h0,        0, 1, 32'h0,        4'h0,    32'h0};
        vt[11] = '{1, F3_BU, 32'h0000_0000, 32'h0,        0,        32'h0,        0, 1, 32'h0,        4'h0,    32'h0};
        vt[12] = '{1, F3_W,  32'h0000_0010, 32'hCAFE_F00D, 1,        32'h0,        1, 0, 32'h0,        4'hF,    32'hCAFE_F00D};
        vt[13] = '{0, F3_H,  32'h0000_0001, 32'h0,        0,        32'h0,        0, 1, 32'h0,        4'h0,    32'h0};

        tick;
        tick;
        chk("reset mem_req", {31'd0, mem.mem_req}, 32'd0);
        chk("reset mem_we", {31'd0, mem.mem_we}, 32'd0);
        chk("reset mem_be", {28'd0, mem.mem_be}, 32'd0);
        chk("reset mem_addr", mem.mem_addr, 32'd0);
        chk("reset mem_wdata", mem.mem_wdata, 32'd0);
        chk("reset rdata", core_rdata, 32'd0);
        chk("reset done", {31'd0, core_done}, 32'd0);
        chk("reset err", {31'd0, core_err}, 32'd0);
        reset = 1'b1;
        tick;

        for (int i = 0; i < 14; i++) do_txn($sformatf("vec%0d", i), vt[i]);

        for (int i = 0; i < 60; i++) begin
            rv.st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) rv.f3 = 3'($urandom_range(0, 7));
            else if (rv.st) rv.f3 = 3'($urandom_range(0, 2));
            else rv.f3 = (i % 2 == 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5));
            rv.a = $urandom;
            if ($urandom_range(0, 3) != 0) rv.a = rv.a & ~((32'd1 << rv.f3[1:0]) - 32'd1);
            rv.wd = $urandom;
            rv.dly = $urandom_range(0, TIMEOUT + 1);
            rv.mr = $urandom;
            rv.legal = m_legal(rv.st, rv.f3, rv.a);
            rv.err = !rv.legal || rv.dly >= TIMEOUT;
            rv.rd = (rv.err || rv.st) ? 32'd0 : m_load(rv.f3, rv.a, rv.mr);
            rv.be = m_be(rv.st, rv.f3, rv.a);
            rv.mwd = m_wdata(rv.f3, rv.wd);
            do_txn($sformatf("rnd%0d", i), rv);
        end

        // Reset pulse in the middle of an access must abort it silently.
        core_valid = 1'b1;
        core_store = 1'b0;
        core_funct3 = F3_W;
        core_addr = 32'h0000_0300;
        mem.mem_ack = 1'b0;
        tick;
        chk("abort req_before", {31'd0, mem.mem_req}, 32'd1);
        tick;
        tick;
        reset = 1'b0;
        tick;
        chk("abort mem_req", {31'd0, mem.mem_req}, 32'd0);
        chk("abort mem_we", {31'd0, mem.mem_we}, 32'd0);
        chk("abort mem_addr", mem.mem_addr, 32'd0);
        chk("abort mem_be", {28'd0, mem.mem_be}, 32'd0);
        chk("abort rdata", core_rdata, 32'd0);
        chk("abort done", {31'd0, core_done}, 32'd0);
        reset = 1'b1;
        core_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("abort no_done", {31'd0, core_done}, 32'd0);
            chk("abort no_req", {31'd0, mem.mem_req}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
